// File: rtl/bram_prog_loader.sv
// Byte-stream program loader: framed bytes -> little-endian words -> instruction BRAM write port.
// Defining LOADER_CHECKSUM_EN adds the trailing mod-256 checksum byte and the CHECK state.
module bram_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic        bram_en_o,
    output logic [3:0]  bram_we_o,
    output logic [31:0] bram_addr_o,
    output logic [31:0] bram_din_o,
    output logic        core_reset_o,
    output logic        load_done_o,
    output logic        load_error_o,
    output logic [15:0] words_written_o
);

    localparam logic [15:0] MaxLen = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`else
        S_FLUSH,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q;
    logic [15:0] len_q;
    logic [1:0]  idx_q;
    logic [23:0] asm_q;
    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic        en_q;
    logic [3:0]  we_q;
    logic [15:0] words_written_q;
    logic        core_reset_q;
    logic        done_q;
    logic        error_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q;
`endif

    logic        accept_d;
    logic [15:0] len_d;
    logic [31:0] word_d;
    logic        last_word_d;

    always_comb begin
        s_ready_o = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA: s_ready_o = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK:                    s_ready_o = 1'b1;
`endif
            default:                    s_ready_o = 1'b0;
        endcase
    end

    // The previous word has always been committed by the time a 4th byte arrives,
    // so the committed count identifies the final word of the image.
    assign accept_d    = s_valid_i & s_ready_o;
    assign len_d       = {s_data_i, len_q[7:0]};
    assign word_d      = {s_data_i, asm_q};
    assign last_word_d = (words_written_q == len_q - 16'd1);

    assign bram_en_o       = en_q;
    assign bram_we_o       = we_q;
    assign bram_addr_o     = addr_q;
    assign bram_din_o      = din_q;
    assign core_reset_o    = core_reset_q;
    assign load_done_o     = done_q;
    assign load_error_o    = error_q;
    assign words_written_o = words_written_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= S_IDLE;
            len_q           <= 16'd0;
            idx_q           <= 2'd0;
            asm_q           <= 24'd0;
            addr_q          <= BASE_ADDR;
            din_q           <= 32'd0;
            en_q            <= 1'b0;
            we_q            <= 4'h0;
            words_written_q <= 16'd0;
            core_reset_q    <= 1'b1;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q           <= 8'd0;
`endif
        end else begin
            // Commit of a write cycle; the stream keeps flowing in parallel.
            if (en_q) begin
                en_q            <= 1'b0;
                we_q            <= 4'h0;
                addr_q          <= addr_q + 32'd4;
                words_written_q <= words_written_q + 16'd1;
            end
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_i) begin
                        state_q         <= S_LEN_LO;
                        core_reset_q    <= 1'b1;
                        done_q          <= 1'b0;
                        error_q         <= 1'b0;
                        words_written_q <= 16'd0;
                    end
                end
                S_LEN_LO: begin
                    if (accept_d) begin
                        len_q[7:0] <= s_data_i;
                        state_q    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept_d) begin
                        len_q <= len_d;
                        if (len_d == 16'd0 || len_d > MaxLen) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end else begin
                            words_written_q <= 16'd0;
                            addr_q          <= BASE_ADDR;
                            idx_q           <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                            sum_q           <= 8'd0;
`endif
                            state_q         <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_d) begin
                        idx_q <= idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q <= sum_q + s_data_i;
`endif
                        case (idx_q)
                            2'd0: asm_q[7:0]   <= s_data_i;
                            2'd1: asm_q[15:8]  <= s_data_i;
                            2'd2: asm_q[23:16] <= s_data_i;
                            default: begin
                                din_q <= word_d;
                                en_q  <= 1'b1;
                                we_q  <= 4'hF;
                                if (last_word_d) begin
`ifdef LOADER_CHECKSUM_EN
                                    state_q <= S_CHECK;
`else
                                    state_q <= S_FLUSH;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept_d) begin
                        if (s_data_i == sum_q) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            core_reset_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`else
                S_FLUSH: begin
                    state_q      <= S_DONE;
                    done_q       <= 1'b1;
                    core_reset_q <= 1'b0;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_prog_loader.sv
// Self-checking bench for bram_prog_loader: random framed images against a word-level model.
// Adapts its expectations to whether LOADER_CHECKSUM_EN is defined.
module tb_bram_prog_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int MAXW = 20;
`ifdef LOADER_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  sData;
    logic        sValid;
    logic        sReady;
    logic        bramEn;
    logic [3:0]  bramWe;
    logic [31:0] bramAddr;
    logic [31:0] bramDin;
    logic        coreReset;
    logic        loadDone;
    logic        loadError;
    logic [15:0] wordsWritten;

    wr_t         expQ[$];
    logic [31:0] imgWords[$];
    logic [31:0] bramMem[0:63];
    int          checks = 0;
    int          errors = 0;
    bit          monitorOn = 1'b0;

    always #5 clk = ~clk;

    bram_prog_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .s_data_i       (sData),
        .s_valid_i      (sValid),
        .s_ready_o      (sReady),
        .bram_en_o      (bramEn),
        .bram_we_o      (bramWe),
        .bram_addr_o    (bramAddr),
        .bram_din_o     (bramDin),
        .core_reset_o   (coreReset),
        .load_done_o    (loadDone),
        .load_error_o   (loadError),
        .words_written_o(wordsWritten)
    );

    // Every cycle the write port must either carry exactly the next expected word
    // (the cycle after its 4th byte was accepted) or be idle.
    always @(negedge clk) begin
        wr_t e;
        if (bramEn) bramMem[bramAddr[7:2]] = bramDin;
        if (monitorOn && !reset) begin
            checks++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                if (bramEn !== 1'b1 || bramWe !== 4'hF || bramAddr !== e.addr || bramDin !== e.data) begin
                    errors++;
                    $display("[TB] FAIL bram_write: got en=%b we=%h addr=%h din=%h, expected en=1 we=f addr=%h din=%h",
                             bramEn, bramWe, bramAddr, bramDin, e.addr, e.data);
                end
            end else if (bramEn !== 1'b0 || bramWe !== 4'h0) begin
                errors++;
                $display("[TB] FAIL bram_idle: got en=%b we=%h, expected en=0 we=0", bramEn, bramWe);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_s_ready"}, 32'(sReady), 32'd0);
        checkOutput({tag, "_bram_en"}, 32'(bramEn), 32'd0);
        checkOutput({tag, "_bram_we"}, 32'(bramWe), 32'd0);
        checkOutput({tag, "_bram_addr"}, bramAddr, BASE);
        checkOutput({tag, "_bram_din"}, bramDin, 32'd0);
        checkOutput({tag, "_core_reset"}, 32'(coreReset), 32'd1);
        checkOutput({tag, "_load_done"}, 32'(loadDone), 32'd0);
        checkOutput({tag, "_load_error"}, 32'(loadError), 32'd0);
        checkOutput({tag, "_words_written"}, 32'(wordsWritten), 32'd0);
    endtask

    // Presents one byte after a random gap (start toggled randomly meanwhile, which a
    // loading FSM must ignore) and holds it until accepted; queues the expected write.
    task automatic applyStimulus(input logic [7:0] b, input int maxGap, input bit pushWr, input wr_t wr);
        int gap;
        int waited;
        gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
        waited = 0;
        for (int i = 0; i < gap; i++) begin
            sValid = 1'b0;
            sData  = 8'($urandom);
            start  = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start  = 1'b0;
        sData  = b;
        sValid = 1'b1;
        while (!sReady && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!sReady) begin
            errors++;
            $display("[TB] FAIL handshake_timeout: got s_ready=0 for %0d cycles, expected 1", waited);
            sValid = 1'b0;
            return;
        end
        @(posedge clk);
        if (pushWr) expQ.push_back(wr);
        @(negedge clk);
        sValid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sendImage(input logic [15:0] lenField, input bit corruptSum, input int maxGap);
        logic [7:0]  sum;
        logic [31:0] cw;
        wr_t         w;
        sum = 8'h00;
        w   = '0;
        pulseStart();
        applyStimulus(lenField[7:0], maxGap, 1'b0, w);
        applyStimulus(lenField[15:8], maxGap, 1'b0, w);
        if (lenField == 16'd0 || lenField > 16'(MAXW)) return;
        for (int k = 0; k < int'(lenField); k++) begin
            cw     = imgWords[k];
            w.addr = BASE + 32'(4 * k);
            w.data = cw;
            for (int j = 0; j < 4; j++) begin
                sum = sum + cw[8*j +: 8];
                applyStimulus(cw[8*j +: 8], maxGap, (j == 3), w);
            end
        end
        if (ChkEn) applyStimulus(corruptSum ? (sum ^ 8'h5A) : sum, maxGap, 1'b0, w);
    endtask

    // Final status from the frame rules: bad length fails right after LEN_HI,
    // a good length commits every word and then fails only on a bad checksum.
    task automatic checkLoad(input logic [15:0] lenField, input bit corruptSum);
        bit          lenOk;
        bit          expDone;
        logic [15:0] expWw;
        int          maxWait;
        int          waited;
        lenOk   = (lenField != 16'd0) && (lenField <= 16'(MAXW));
        expDone = lenOk && !(ChkEn && corruptSum);
        expWw   = lenOk ? lenField : 16'd0;
        maxWait = lenOk ? 4 : 0;
        waited  = 0;
        while (!(loadDone || loadError) && waited < maxWait) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("load_done", 32'(loadDone), 32'(expDone));
        checkOutput("load_error", 32'(loadError), 32'(!expDone));
        checkOutput("core_reset", 32'(coreReset), 32'(!expDone));
        checkOutput("words_written", 32'(wordsWritten), 32'(expWw));
        checkOutput("s_ready_final", 32'(sReady), 32'd0);
        checkOutput("pending_writes", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed frames from the plan, then randomized images, then reset mid-load.
    initial begin
        logic [31:0] oldWord1;
        wr_t         w;
        reset  = 1'b1;
        start  = 1'b0;
        sValid = 1'b0;
        sData  = 8'h00;
        for (int i = 0; i < 64; i++) bramMem[i] = 32'h0;
        repeat (2) @(negedge clk);
        checkResetValues("rst");
        reset     = 1'b0;
        monitorOn = 1'b1;
        @(negedge clk);
        checkOutput("idle_s_ready", 32'(sReady), 32'd0);

        imgWords = '{32'h12345678, 32'hDEADBEEF};
        sendImage(16'd2, 1'b0, 0);
        checkLoad(16'd2, 1'b0);
        checkOutput("t1_word0", bramMem[0], 32'h12345678);
        checkOutput("t1_word1", bramMem[1], 32'hDEADBEEF);
        checkOutput("t1_ww_literal", 32'(wordsWritten), 32'd2);
        for (int i = 0; i < 4; i++) begin
            sData  = 8'($urandom);
            sValid = 1'b1;
            @(negedge clk);
        end
        sValid = 1'b0;
        checkLoad(16'd2, 1'b0);

        pulseStart();
        checkOutput("restart_core_reset", 32'(coreReset), 32'd1);
        checkOutput("restart_load_done", 32'(loadDone), 32'd0);

        sendImage(16'd0, 1'b0, 0);
        checkLoad(16'd0, 1'b0);
        checkOutput("t2_error_literal", 32'(loadError), 32'd1);

        sendImage(16'(MAXW + 1), 1'b0, 1);
        checkLoad(16'(MAXW + 1), 1'b0);

        imgWords = '{32'h44332211};
        sendImage(16'd1, 1'b1, 0);
        checkLoad(16'd1, 1'b1);
        checkOutput("t4_word", bramMem[0], 32'h44332211);

        imgWords.delete();
        for (int k = 0; k < MAXW; k++) imgWords.push_back($urandom);
        sendImage(16'(MAXW), 1'b0, 1);
        checkLoad(16'(MAXW), 1'b0);

        imgWords.delete();
        for (int k = 0; k < 16; k++) imgWords.push_back($urandom);
        sendImage(16'd16, 1'b0, 3);
        checkLoad(16'd16, 1'b0);
        for (int k = 0; k < 16; k++) checkOutput("t5_bram", bramMem[k], imgWords[k]);

        for (int it = 0; it < 20; it++) begin
            logic [15:0] lf;
            bit          bad;
            case ($urandom_range(0, 9))
                0:       lf = 16'd0;
                1:       lf = 16'(MAXW + 1 + int'($urandom_range(0, 100)));
                default: lf = 16'($urandom_range(1, MAXW));
            endcase
            bad = ($urandom_range(0, 3) == 0);
            imgWords.delete();
            for (int k = 0; k < MAXW; k++) imgWords.push_back($urandom);
            sendImage(lf, bad, 3);
            checkLoad(lf, bad);
        end

        imgWords.delete();
        for (int k = 0; k < 3; k++) imgWords.push_back($urandom);
        oldWord1 = imgWords[1];
        pulseStart();
        w = '0;
        applyStimulus(8'd3, 1, 1'b0, w);
        applyStimulus(8'd0, 1, 1'b0, w);
        for (int n = 0; n < 10; n++) begin
            logic [31:0] cw;
            cw     = imgWords[n / 4];
            w.addr = BASE + 32'(4 * (n / 4));
            w.data = cw;
            applyStimulus(cw[8*(n % 4) +: 8], 2, ((n % 4) == 3), w);
        end
        checkOutput("t6_pending", 32'(expQ.size()), 32'd0);
        reset = 1'b1;
        #1;
        checkResetValues("midrst");
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        @(negedge clk);
        imgWords = '{32'(~oldWord1)};
        sendImage(16'd1, 1'b0, 1);
        checkLoad(16'd1, 1'b0);
        checkOutput("t6_new_word", bramMem[0], ~oldWord1);
        checkOutput("t6_old_word1", bramMem[1], oldWord1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
